// File: rtl/mac_core.sv
// Sequential signed multiply-accumulate: radix-2 Booth multiply, one multiplier bit
// per cycle, with the exact product added into a wrapping double-width accumulator.
module mac_core #(
    parameter int OPSIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OPSIZE-1:0]     a,
    input  logic [OPSIZE-1:0]     b,
    output logic [2*OPSIZE-1:0]   out,
    output logic                  ready
);

    // Booth register layout: {upper[OPSIZE:0], multiplier[OPSIZE-1:0], q_minus1}.
    // The upper half carries one guard bit so that -(-2^(OPSIZE-1)) fits.
    localparam int PW = 2*OPSIZE + 2;
    localparam int CW = $clog2(OPSIZE + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
    } state_t;

    state_t                state_q, state_d;
    logic [OPSIZE-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]         prod_q, prod_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2*OPSIZE-1:0]   acc_q, acc_d;
    logic                  ready_q, ready_d;

    logic [OPSIZE:0]       upper;
    logic [OPSIZE:0]       mext;
    logic [OPSIZE:0]       sum;

    always_comb begin
        upper = prod_q[PW-1:OPSIZE+1];
        mext  = {mcand_q[OPSIZE-1], mcand_q};
        case (prod_q[1:0])
            2'b01:   sum = upper + mext;
            2'b10:   sum = upper - mext;
            default: sum = upper;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    prod_d  = {{(OPSIZE+1){1'b0}}, b, 1'b0};
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = MUL;
                end
            end
            MUL: begin
                prod_d = {sum[OPSIZE], sum, prod_q[OPSIZE:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(OPSIZE - 1)) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                // Product is the low 2*OPSIZE bits above the Booth history bit.
                acc_d   = acc_q + prod_q[2*OPSIZE:1];
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ready_q <= ready_d;
        end
    end

    assign out   = acc_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_mac_core.sv
// Scoreboard bench for mac_core (OPSIZE=16): a cycle model queues expected results
// at acceptance; a monitor pops and compares on each ready rising edge.
module tb_mac_core;

    localparam int N = 16;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic [31:0] out;
    logic        ready;

    mac_core #(.OPSIZE(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .out   (out),
        .ready (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cyc        = 0;
    int   model_cnt  = 0;
    int   model_acc  = 0;
    int   comp_count = 0;
    logic ready_prev = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepts when idle, busy for N+1 cycles afterwards.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                model_cnt = 0;
                model_acc = 0;
                sb.delete();
            end else if (clk) begin
                cyc++;
                if (model_cnt > 0) begin
                    model_cnt--;
                end else if (start) begin
                    logic signed [15:0] sa;
                    logic signed [15:0] sb16;
                    sa = a;
                    sb16 = b;
                    model_acc = model_acc + int'(sa) * int'(sb16);
                    sb.push_back('{32'(model_acc), cyc + N + 1});
                    model_cnt = N + 1;
                    $display("issue a=%h b=%h expect out=%h at cycle %0d", a, b, 32'(model_acc), cyc + N + 1);
                end
            end
        end
    end

    // Monitor: ready timing every cycle, result comparison on each completion.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("ready_timing", 32'(ready), 32'(model_cnt == 0));
                if (ready && !ready_prev) begin
                    comp_count++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: out=%h with no operation pending", out);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        $display("done out=%h cycle=%0d (expected %h at %0d)", out, cyc, e.val, e.cyc);
                        chk("result", out, e.val);
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
            ready_prev = ready;
        end
    end

    task automatic wait_idle();
        int g = 0;
        while ((model_cnt != 0 || sb.size() != 0) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: pending=%0d model_cnt=%0d", sb.size(), model_cnt);
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv);
        wait_idle();
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 16'($urandom);
        b     = 16'($urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int c0;
        repeat (2) @(negedge clk);
        chk("reset_out", out, 32'h0);
        chk("reset_ready", 32'(ready), 32'h1);
        reset = 1'b1;

        // Reset mid-operation discards the product
        do_op(16'd3, 16'd5);
        wait_idle();
        chk("pre_abort_out", out, 32'd15);
        do_op(16'h1234, 16'h0101);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_out", out, 32'h0);
        chk("abort_ready", 32'(ready), 32'h1);
        @(negedge clk);
        reset = 1'b1;

        // Accepted on the first edge after release, then accumulate to zero
        do_op(16'h7FFF, 16'h7FFF);
        wait_idle();
        chk("max_pos_out", out, 32'h3FFF0001);
        do_op(16'h8001, 16'h7FFF);
        wait_idle();
        chk("accumulate_out", out, 32'h00000000);

        // Extreme operands and wrap
        do_reset();
        do_op(16'h8000, 16'h8000);
        wait_idle();
        chk("min_sq_out", out, 32'h40000000);
        do_op(16'h8000, 16'h8000);
        wait_idle();
        chk("wrap_out", out, 32'h80000000);

        // Sign handling
        do_reset();
        do_op(16'hFFFF, 16'hFFFF);
        wait_idle();
        chk("neg_neg_out", out, 32'h00000001);
        do_op(16'hFFFF, 16'h0002);
        wait_idle();
        chk("neg_pos_out", out, 32'hFFFFFFFF);

        // start held high: back-to-back operations every N+2 cycles
        do_reset();
        c0 = comp_count;
        a = 16'd1;
        b = 16'd1;
        start = 1'b1;
        repeat (50) @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("b2b_count", 32'(comp_count - c0), 32'd3);
        chk("b2b_out", out, 32'd3);

        // Operand changes during MUL are ignored
        do_reset();
        do_op(16'h0123, 16'h0045);
        for (int i = 0; i < N; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
        end
        wait_idle();
        chk("toggle_out", out, 32'h00004E6F);

        // start while busy is neither honoured nor queued
        do_reset();
        do_op(16'hFFFD, 16'h0007);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("busy_ignore_out", out, 32'hFFFFFFEB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
